// File: rtl/rv32v_ex_sequencer.sv
// rv32v_ex_sequencer: splits a vector instruction of length vl into
// LANES-wide chunks, one chunk per unstalled cycle, toward the memory stage.
// busy_ex asks the hazard unit to hold decode while chunks remain.
// Optional macro RV32V_EX_SEQ_PERF_EN adds a saturating stall_cycles counter.
module rv32v_ex_sequencer #(
  parameter int LANES = 4,
  parameter int VL_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dec_valid,
  input  logic [VL_W-1:0]   dec_vl,
  input  logic [4:0]        dec_vd,
  input  logic              stall_ex,
  input  logic              flush_ex,
  output logic              busy_ex,
  output logic              out_valid,
  output logic [VL_W-1:0]   out_idx,
  output logic [LANES-1:0]  out_mask,
  output logic              out_last,
  output logic [4:0]        out_vd
`ifdef RV32V_EX_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // One extra bit so next index + LANES can never wrap past vl.
  localparam logic [VL_W:0] LANES_W = (VL_W+1)'(LANES);

  state_t             state_reg;
  logic [VL_W:0]      next_idx_reg;
  logic [VL_W:0]      vl_reg;
  logic [4:0]         vd_reg;
  logic               out_valid_reg;
  logic [VL_W-1:0]    out_idx_reg;
  logic [LANES-1:0]   out_mask_reg;
  logic               out_last_reg;
  logic [4:0]         out_vd_reg;

  logic [LANES-1:0]   accept_mask;
  logic [LANES-1:0]   run_mask;
  logic               accept_last;
  logic               run_last;

  // Per-lane activity for the first chunk (from decode) and for later chunks.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [VL_W:0] LANE_OFS = (VL_W+1)'(gi);
      assign accept_mask[gi] = LANE_OFS < {1'b0, dec_vl};
      assign run_mask[gi]    = (next_idx_reg + LANE_OFS) < vl_reg;
    end
  endgenerate

  assign accept_last = {1'b0, dec_vl} <= LANES_W;
  assign run_last    = (next_idx_reg + LANES_W) >= vl_reg;

  // busy_ex depends on state only, so the hazard unit sees no loop through it.
  assign busy_ex   = (state_reg == RUN);
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_mask  = out_mask_reg;
  assign out_last  = out_last_reg;
  assign out_vd    = out_vd_reg;

  // Sequencer FSM with registered chunk outputs; reset > flush > stall > issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      next_idx_reg  <= '0;
      vl_reg        <= '0;
      vd_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_mask_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_vd_reg    <= '0;
    end else if (flush_ex) begin
      state_reg     <= IDLE;
      next_idx_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_mask_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (!stall_ex) begin
      // Default: no chunk this cycle; overridden below when one issues.
      out_valid_reg <= 1'b0;
      out_mask_reg  <= '0;
      out_last_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dec_valid && (dec_vl != '0)) begin
            vl_reg        <= {1'b0, dec_vl};
            vd_reg        <= dec_vd;
            out_valid_reg <= 1'b1;
            out_idx_reg   <= '0;
            out_mask_reg  <= accept_mask;
            out_last_reg  <= accept_last;
            out_vd_reg    <= dec_vd;
            if (!accept_last) begin
              next_idx_reg <= LANES_W;
              state_reg    <= RUN;
            end
          end
        end
        RUN: begin
          out_valid_reg <= 1'b1;
          out_idx_reg   <= next_idx_reg[VL_W-1:0];
          out_mask_reg  <= run_mask;
          out_last_reg  <= run_last;
          out_vd_reg    <= vd_reg;
          next_idx_reg  <= next_idx_reg + LANES_W;
          if (run_last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef RV32V_EX_SEQ_PERF_EN
  logic [31:0] stall_cycles_reg;
  assign stall_cycles = stall_cycles_reg;

  // Count stalled RUN cycles, saturating; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles_reg <= '0;
    end else if ((state_reg == RUN) && stall_ex && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end
`endif

endmodule

// File: doc/rv32v_ex_sequencer.md
RV32V_EX_SEQUENCER -- requirements
Module: rv32v_ex_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of element lanes per chunk (power of two, >=1).
REQ-002 SHALL have parameter VL_W, default 8, width of the vector-length and element-index fields.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port dec_valid  input  1  decode presents a vector instruction.
REQ-006 SHALL have port dec_vl  input  VL_W  active vector length of the presented instruction.
REQ-007 SHALL have port dec_vd  input  5  destination vector register of the presented instruction.
REQ-008 SHALL have port stall_ex  input  1  execute-stage stall from the hazard unit.
REQ-009 SHALL have port flush_ex  input  1  execute-stage flush from the hazard unit.
REQ-010 SHALL have port busy_ex  output  1  remaining chunks pending; stall request to the hazard unit.
REQ-011 SHALL have port out_valid  output  1  chunk valid toward memory stage.
REQ-012 SHALL have port out_idx  output  VL_W  element index of lane 0 of the chunk.
REQ-013 SHALL have port out_mask  output  LANES  per-lane active mask.
REQ-014 SHALL have port out_last  output  1  chunk is the final chunk of the instruction.
REQ-015 SHALL have port out_vd  output  5  destination register of the chunk.

Function
REQ-016 SHALL implement two states, IDLE and RUN, with busy_ex = (state==RUN), combinational from state only; no path from stall_ex or flush_ex to busy_ex.
REQ-017 SHALL accept an instruction in IDLE when dec_valid && !stall_ex && !flush_ex; nothing is accepted in RUN or under stall.
REQ-018 On accept with dec_vl==0: no-op; out_valid 0 next cycle; state stays IDLE.
REQ-019 On accept with dec_vl>0: next cycle out_valid=1, out_idx=0, out_vd=dec_vd, out_mask lane i = (i < dec_vl); vl and vd are latched.
REQ-020 If dec_vl<=LANES at accept, out_last=1 and state stays IDLE; otherwise out_last=0, next index=LANES, state->RUN.
REQ-021 In RUN with !stall_ex && !flush_ex: register chunk at next index (mask lane i = next+i < vl, out_last = next+LANES >= vl), advance next by LANES; on last chunk state->IDLE.
REQ-022 Index and compare arithmetic SHALL use VL_W+1 bits so next+LANES never wraps (vl=255, LANES=4: final chunk idx 252, mask 4'b0111).
REQ-023 While stall_ex=1 (flush_ex=0): all out_* registers, next index and state hold.
REQ-024 With !stall_ex and no chunk issued this cycle: out_valid, out_last, out_mask cleared to 0 next cycle.
REQ-025 flush_ex SHALL take priority over stall_ex and accept: next cycle state=IDLE, out_valid=0, out_last=0, out_mask=0; pending chunks discarded.
REQ-026 Back-to-back: an instruction presented in the cycle the last chunk is registered is not accepted (state still RUN); accepted the following cycle.

Reset
REQ-027 RST=1 at a rising edge SHALL set state=IDLE, next index=0, latched vl=0, out_valid=0, out_idx=0, out_mask=0, out_last=0, out_vd=0; busy_ex=0 from that cycle.
REQ-028 RST SHALL take priority over flush_ex, stall_ex and dec_valid, including mid-instruction in RUN.

Configuration
REQ-029 Macro RV32V_EX_SEQ_PERF_EN SHALL, when defined, add output stall_cycles (32 bits): counts cycles with state==RUN && stall_ex, saturating at 32'hFFFFFFFF, reset to 0 by RST only, unaffected by flush_ex.
REQ-030 Without RV32V_EX_SEQ_PERF_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 LANES=4, vl=10, vd=3, no stalls -> chunks idx 0/4/8, masks 1111/1111/0011, out_last only on idx 8, busy_ex high 2 cycles.
REQ-032 vl=10, stall_ex high 3 cycles after first chunk -> idx 0 outputs held 3 extra cycles, sequence then resumes 4, 8; stall_cycles=3 with macro on.
REQ-033 vl=10, flush_ex asserted with stall_ex after first chunk -> next cycle out_valid=0, busy_ex=0; next dec_valid accepted normally.
REQ-034 vl=0 then vl=3 -> no chunk for first; second gives single chunk idx 0, mask 0111, out_last=1, busy_ex never high.
REQ-035 vl=255 -> 64 chunks, final idx 252 mask 0111 out_last=1; RST asserted at chunk 30 in a rerun -> all outputs 0, state IDLE next cycle.
